itlb_cache: RTL and testbench



---
 rtl/cpu_defs.sv | 29 ++
 rtl/itlb_match.sv | 25 ++
 rtl/itlb_cache.sv | 127 ++++++++++++
 tb/tb_itlb_cache.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: main-TLB lookup result, micro-TLB entry layout and sizing.
package cpu_defs;

  localparam int unsigned ITLB_ENTRIES = 4;
  localparam int unsigned VPN_W        = 20;
  localparam int unsigned PFN_W        = 20;
  localparam int unsigned CFLAG_W      = 3;

  typedef struct packed {
    logic               miss;
    logic               valid;
    logic               dirty;
    logic [CFLAG_W-1:0] cache_flag;
    logic [31:0]        phys_addr;
  } tlb_result_t;

  typedef struct packed {
    logic               valid;
    logic [VPN_W-1:0]   vpn;
    logic [PFN_W-1:0]   pfn;
    logic [CFLAG_W-1:0] cached;
  } itlb_entry_t;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } itlb_state_t;

endpackage

// File: rtl/itlb_match.sv
// Fully-associative VPN compare over the micro-TLB; lowest matching index wins.
module itlb_match
  import cpu_defs::*;
#(
  parameter int unsigned ENTRIES = ITLB_ENTRIES,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  itlb_entry_t      entries [ENTRIES],
  input  logic [VPN_W-1:0] vpn,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
);

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].vpn == vpn)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/itlb_cache.sv
// Instruction micro-TLB: 1-cycle hits from local entries, one-cycle main-TLB
// lookup on a miss, refill only with valid translations.
module itlb_cache
  import cpu_defs::*;
#(
  parameter int unsigned ENTRIES = ITLB_ENTRIES,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  input  logic [31:0]        req_vaddr,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [31:0]        resp_paddr,
  output logic               resp_miss,
  output logic               resp_invalid,
  output logic [CFLAG_W-1:0] resp_cached,
  output logic [31:0]        tlb_vaddr,
  input  tlb_result_t        tlb_result
);

  itlb_state_t       state;
  itlb_entry_t       entries [ENTRIES];
  logic [IDX_W-1:0]  ptr;
  logic [31:0]       saved_vaddr;

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  victim;
  logic              fill_en;
  logic              unused_dirty;

  assign unused_dirty = tlb_result.dirty;

  itlb_match #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_match (
    .entries (entries),
    .vpn     (req_vaddr[31:12]),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  assign req_ready = (state == S_IDLE);
  // Outside a refill the lookup port just follows the request address.
  assign tlb_vaddr = (state == S_REFILL) ? saved_vaddr : req_vaddr;

  // Victim: lowest free slot, else the round-robin pointer.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign victim  = free_found ? free_idx : ptr;
  assign fill_en = (state == S_REFILL) && !flush && !tlb_result.miss && tlb_result.valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      saved_vaddr  <= '0;
      resp_valid   <= 1'b0;
      resp_paddr   <= '0;
      resp_miss    <= 1'b0;
      resp_invalid <= 1'b0;
      resp_cached  <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries[i] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (hit) begin
              resp_valid   <= 1'b1;
              resp_paddr   <= {entries[hit_idx].pfn, req_vaddr[11:0]};
              resp_miss    <= 1'b0;
              resp_invalid <= 1'b0;
              resp_cached  <= entries[hit_idx].cached;
            end else begin
              saved_vaddr <= req_vaddr;
              state       <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          resp_valid   <= 1'b1;
          resp_paddr   <= tlb_result.phys_addr;
          resp_miss    <= tlb_result.miss;
          resp_invalid <= !tlb_result.miss && !tlb_result.valid;
          resp_cached  <= tlb_result.cache_flag;
          state        <= S_IDLE;
          if (fill_en) begin
            entries[victim] <= '{valid:  1'b1,
                                 vpn:    saved_vaddr[31:12],
                                 pfn:    tlb_result.phys_addr[31:12],
                                 cached: tlb_result.cache_flag};
            if (!free_found) begin
              ptr <= IDX_W'(ptr + 1'b1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // Flush wins over any fill; a hit resolved this cycle still responds.
      if (flush) begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
          entries[i].valid <= 1'b0;
        end
        ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_itlb_cache.sv
// Self-checking bench for itlb_cache: directed scenarios plus randomized traffic
// against a table-based reference model of the micro-TLB.
module tb_itlb_cache;
  import cpu_defs::*;

  localparam int unsigned E = ITLB_ENTRIES;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_miss;
  logic        resp_invalid;
  logic [2:0]  resp_cached;
  logic [31:0] tlb_vaddr;
  tlb_result_t tlb_result;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain table of translations and a replacement pointer.
  bit          m_valid  [E];
  logic [19:0] m_vpn    [E];
  logic [19:0] m_pfn    [E];
  logic [2:0]  m_cached [E];
  int          m_ptr;

  itlb_cache dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_vaddr    (req_vaddr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_paddr   (resp_paddr),
    .resp_miss    (resp_miss),
    .resp_invalid (resp_invalid),
    .resp_cached  (resp_cached),
    .tlb_vaddr    (tlb_vaddr),
    .tlb_result   (tlb_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic tlb_result_t mk_tr(input bit miss, input bit valid, input logic [2:0] cf,
                                        input logic [31:0] pa);
    tlb_result_t t;
    t.miss       = miss;
    t.valid      = valid;
    t.dirty      = 1'b0;
    t.cache_flag = cf;
    t.phys_addr  = pa;
    return t;
  endfunction

  task automatic model_clear(input bit clr_ptr);
    for (int i = 0; i < int'(E); i++) m_valid[i] = 1'b0;
    if (clr_ptr) m_ptr = 0;
  endtask

  task automatic model_lookup(input logic [19:0] vpn, output bit h, output int idx);
    h   = 1'b0;
    idx = 0;
    for (int i = 0; i < int'(E); i++) begin
      if (!h && m_valid[i] && m_vpn[i] == vpn) begin
        h   = 1'b1;
        idx = i;
      end
    end
  endtask

  task automatic model_fill(input logic [19:0] vpn, input tlb_result_t t);
    int v = -1;
    for (int i = 0; i < int'(E); i++) if (v < 0 && !m_valid[i]) v = i;
    if (v < 0) begin
      v     = m_ptr;
      m_ptr = (m_ptr + 1) % int'(E);
    end
    m_valid[v]  = 1'b1;
    m_vpn[v]    = vpn;
    m_pfn[v]    = t.phys_addr[31:12];
    m_cached[v] = t.cache_flag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear(1'b1);
  endtask

  // One translation; flags inject a flush at accept, a flush in refill, or a reset in refill.
  task automatic txn(input logic [31:0] va, input tlb_result_t t,
                     input bit fl_acc, input bit fl_ref, input bit rst_ref);
    bit h;
    int idx;
    chk("ready_idle", 32'(req_ready), 32'd1);
    model_lookup(va[31:12], h, idx);
    req_valid  = 1'b1;
    req_vaddr  = va;
    tlb_result = t;
    flush      = fl_acc;
    #1;
    chk("tlb_vaddr_idle", tlb_vaddr, va);
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    if (h) begin
      chk("hit_valid",   32'(resp_valid), 32'd1);
      chk("hit_paddr",   resp_paddr, {m_pfn[idx], va[11:0]});
      chk("hit_miss",    32'(resp_miss), 32'd0);
      chk("hit_invalid", 32'(resp_invalid), 32'd0);
      chk("hit_cached",  32'(resp_cached), 32'(m_cached[idx]));
      if (fl_acc) model_clear(1'b1);
    end else begin
      if (fl_acc) model_clear(1'b1);
      chk("miss_nores",    32'(resp_valid), 32'd0);
      chk("miss_notready", 32'(req_ready), 32'd0);
      chk("refill_vaddr",  tlb_vaddr, va);
      flush = fl_ref;
      rst   = rst_ref;
      @(posedge clk); #1;
      flush = 1'b0;
      rst   = 1'b0;
      if (rst_ref) begin
        chk("rst_nores", 32'(resp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        model_clear(1'b1);
      end else begin
        chk("ref_valid",   32'(resp_valid), 32'd1);
        chk("ref_paddr",   resp_paddr, t.phys_addr);
        chk("ref_miss",    32'(resp_miss), 32'(t.miss));
        chk("ref_invalid", 32'(resp_invalid), 32'(!t.miss && !t.valid));
        chk("ref_cached",  32'(resp_cached), 32'(t.cache_flag));
        if (fl_ref) model_clear(1'b1);
        else if (!t.miss && t.valid) model_fill(va[31:12], t);
      end
    end
  endtask

  task automatic flush_cycle();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_nores", 32'(resp_valid), 32'd0);
    model_clear(1'b1);
  endtask

  initial begin
    logic [31:0] va4 [4];
    tlb_result_t t;
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_vaddr  = '0;
    tlb_result = '0;
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_paddr",      resp_paddr, 32'd0);
    chk("rst_miss",       32'(resp_miss), 32'd0);
    chk("rst_invalid",    32'(resp_invalid), 32'd0);
    chk("rst_cached",     32'(resp_cached), 32'd0);
    chk("rst_ready",      32'(req_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss then hit.
    t = mk_tr(1'b0, 1'b1, 3'd3, 32'h1F00_1234);
    txn(32'h0040_1234, t, 0, 0, 0);
    txn(32'h0040_1234, mk_tr(1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF), 0, 0, 0);
    // Main-TLB miss twice, no fill.
    t = mk_tr(1'b1, 1'b0, 3'd2, 32'h0000_0000);
    txn(32'h0080_0000, t, 0, 0, 0);
    txn(32'h0080_0000, t, 0, 0, 0);
    // Invalid page.
    txn(32'h0090_0ABC, mk_tr(1'b0, 1'b0, 3'd5, 32'h2200_0ABC), 0, 0, 0);
    txn(32'h0090_0ABC, mk_tr(1'b0, 1'b0, 3'd5, 32'h2200_0ABC), 0, 0, 0);

    // Replacement: fifth distinct vpn evicts entry 0.
    do_reset();
    for (int i = 0; i < 5; i++)
      txn({20'h00400 + 20'(i), 12'h010}, mk_tr(1'b0, 1'b1, 3'(i), {20'h10000 + 20'(i), 12'h010}), 0, 0, 0);
    txn(32'h0040_1FFC, mk_tr(1'b1, 1'b0, 3'd0, 32'h0), 0, 0, 0);
    txn(32'h0040_0FFC, mk_tr(1'b1, 1'b0, 3'd0, 32'h0), 0, 0, 0);

    // Flush after two fills, then flush during refill.
    do_reset();
    txn(32'h0050_0000, mk_tr(1'b0, 1'b1, 3'd3, 32'h0A00_0000), 0, 0, 0);
    txn(32'h0051_0000, mk_tr(1'b0, 1'b1, 3'd3, 32'h0A10_0000), 0, 0, 0);
    flush_cycle();
    txn(32'h0050_0004, mk_tr(1'b1, 1'b0, 3'd0, 32'h0), 0, 0, 0);
    txn(32'h0051_0008, mk_tr(1'b1, 1'b0, 3'd0, 32'h0), 0, 0, 0);
    txn(32'h0070_0000, mk_tr(1'b0, 1'b1, 3'd2, 32'h0B00_0000), 0, 1, 0);
    txn(32'h0070_0000, mk_tr(1'b0, 1'b1, 3'd2, 32'h0B00_0000), 0, 0, 0);
    // Flush coinciding with a hitting accept still answers the hit.
    txn(32'h0070_0040, mk_tr(1'b1, 1'b0, 3'd0, 32'h0), 1, 0, 0);
    txn(32'h0070_0040, mk_tr(1'b1, 1'b0, 3'd0, 32'h0), 0, 0, 0);

    // Back-to-back hits.
    do_reset();
    for (int i = 0; i < 4; i++)
      txn({20'h00600 + 20'(i), 12'h000}, mk_tr(1'b0, 1'b1, 3'(i + 1), {20'h30000 + 20'(i), 12'h000}), 0, 0, 0);
    for (int i = 0; i < 4; i++) va4[i] = {20'h00603 - 20'(i), 12'($urandom)};
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit h;
      int idx;
      model_lookup(va4[i][31:12], h, idx);
      req_vaddr = va4[i];
      @(posedge clk); #1;
      chk("b2b_valid",  32'(resp_valid), 32'd1);
      chk("b2b_paddr",  resp_paddr, {m_pfn[idx], va4[i][11:0]});
      chk("b2b_cached", 32'(resp_cached), 32'(m_cached[idx]));
      chk("b2b_ready",  32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", 32'(resp_valid), 32'd0);

    // Reset mid-refill.
    txn(32'h0077_7000, mk_tr(1'b0, 1'b1, 3'd1, 32'h0C00_0000), 0, 0, 1);
    txn(32'h0060_0000, mk_tr(1'b1, 1'b0, 3'd0, 32'h0), 0, 0, 0);

    // Randomized traffic over a small vpn pool.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] va;
      va = {20'h00100 + 20'($urandom_range(0, 5)), 12'($urandom)};
      t  = mk_tr(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0),
                 3'($urandom), 32'($urandom));
      txn(va, t, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        chk("idle_nores", 32'(resp_valid), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
